// File: rtl/pio_edge_servicer_if.sv
`default_nettype none
// ============================================================================
// Module      : pio_edge_servicer_if
// Description : Avalon-MM bus bundle between pio_edge_servicer and a button
//               PIO s1 slave, including the PIO interrupt line.
//   avm_address    : PIO register select (0 data, 2 irq_mask, 3 edge_capture)
//   avm_chipselect : PIO select
//   avm_write_n    : active-low write strobe
//   avm_writedata  : write data
//   avm_readdata   : read data, fixed read latency 1
//   irq            : PIO interrupt
// Revision    : 1.0 - initial release
// ============================================================================
interface pio_edge_servicer_if;
   logic [1:0]  avm_address;
   logic        avm_chipselect;
   logic        avm_write_n;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata;
   logic        irq;

   modport master (
      output avm_address, avm_chipselect, avm_write_n, avm_writedata,
      input  avm_readdata, irq
   );

   modport slave (
      input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
      output avm_readdata, irq
   );
endinterface
`default_nettype wire

// File: rtl/pio_edge_servicer.sv
`default_nettype none
// ============================================================================
// Module      : pio_edge_servicer
// Description : Avalon-MM master that services a single-bit edge-capture PIO.
//               Arms the PIO irq mask after reset, then on irq reads and
//               clears edge_capture, pulses event_pulse, counts the event and
//               waits out a bounce hold-off window.
// Ports       : clk, reset_n (async, active-low)
//               avm         : pio_edge_servicer_if.master (bus + irq)
//               event_pulse : one-cycle pulse per serviced edge
//               event_count : serviced-edge count (wraps)
//               busy        : high whenever not idle
//               pin_level   : last sampled pin level (optional)
// Options     : define PIO_SVC_LEVEL_READ_EN to add the pin-level read-back
// Revision    : 1.0 - initial release
// ============================================================================
module pio_edge_servicer #(
   parameter int HOLDOFF_CYCLES = 50000,
   parameter int CNT_W          = 16
) (
   input  wire logic             clk,
   input  wire logic             reset_n,
   pio_edge_servicer_if.master   avm,
   output logic                  event_pulse,
   output logic [CNT_W-1:0]      event_count,
   output logic                  busy
`ifdef PIO_SVC_LEVEL_READ_EN
   ,
   output logic                  pin_level
`endif
);

   localparam logic [1:0]  ADDR_DATA = 2'd0;
   localparam logic [1:0]  ADDR_MASK = 2'd2;
   localparam logic [1:0]  ADDR_CAP  = 2'd3;
   localparam logic [23:0] HOLD_LOAD = 24'(HOLDOFF_CYCLES - 1);

   // S_RESET is the state held while reset_n is low; it keeps every output
   // at its reset value and hands over to S_INIT on the first clock edge.
   typedef enum logic [3:0] {
      S_RESET,
      S_INIT,
      S_IDLE,
      S_RD_CAP,
      S_RD_WAIT,
      S_CLR,
`ifdef PIO_SVC_LEVEL_READ_EN
      S_RD_LVL,
      S_LVL_WAIT,
`endif
      S_EVENT,
      S_HOLDOFF
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [23:0] hold_cnt;

   // Only bit 0 of the PIO read data carries information.
   logic unused_rdata;
   assign unused_rdata = ^avm.avm_readdata[31:1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_RESET;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt          = state;
      avm.avm_chipselect = 1'b0;
      avm.avm_write_n    = 1'b1;
      avm.avm_address    = ADDR_DATA;
      avm.avm_writedata  = 32'd0;
      event_pulse        = 1'b0;
      case (state)
         S_RESET: begin
            state_nxt = S_INIT;
         end
         S_INIT: begin
            avm.avm_chipselect = 1'b1;
            avm.avm_write_n    = 1'b0;
            avm.avm_address    = ADDR_MASK;
            avm.avm_writedata  = 32'd1;
            state_nxt          = S_IDLE;
         end
         S_IDLE: begin
            if (avm.irq) state_nxt = S_RD_CAP;
         end
         S_RD_CAP: begin
            avm.avm_chipselect = 1'b1;
            avm.avm_address    = ADDR_CAP;
            state_nxt          = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            // Read data of the RD_CAP access is valid this cycle.
            avm.avm_address = ADDR_CAP;
            state_nxt       = avm.avm_readdata[0] ? S_CLR : S_IDLE;
         end
         S_CLR: begin
            avm.avm_chipselect = 1'b1;
            avm.avm_write_n    = 1'b0;
            avm.avm_address    = ADDR_CAP;
            avm.avm_writedata  = 32'd1;
`ifdef PIO_SVC_LEVEL_READ_EN
            state_nxt          = S_RD_LVL;
`else
            state_nxt          = S_EVENT;
`endif
         end
`ifdef PIO_SVC_LEVEL_READ_EN
         S_RD_LVL: begin
            avm.avm_chipselect = 1'b1;
            avm.avm_address    = ADDR_DATA;
            state_nxt          = S_LVL_WAIT;
         end
         S_LVL_WAIT: begin
            state_nxt = S_EVENT;
         end
`endif
         S_EVENT: begin
            event_pulse = 1'b1;
            state_nxt   = (HOLDOFF_CYCLES == 0) ? S_IDLE : S_HOLDOFF;
         end
         S_HOLDOFF: begin
            if (hold_cnt == 24'd0) state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_RESET;
         end
      endcase
   end

   // busy must also read low during reset, hence the S_RESET exclusion.
   assign busy = (state != S_IDLE) && (state != S_RESET);

   // Hold-off counter is loaded while in EVENT so the first HOLDOFF cycle
   // already sees HOLDOFF_CYCLES-1; HOLDOFF therefore lasts exactly
   // HOLDOFF_CYCLES cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_cnt    <= 24'd0;
         event_count <= '0;
      end else begin
         if (state == S_EVENT) begin
            hold_cnt    <= HOLD_LOAD;
            event_count <= event_count + 1'b1;
         end else if ((state == S_HOLDOFF) && (hold_cnt != 24'd0)) begin
            hold_cnt <= hold_cnt - 24'd1;
         end
      end
   end

`ifdef PIO_SVC_LEVEL_READ_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pin_level <= 1'b0;
      end else if (state == S_LVL_WAIT) begin
         pin_level <= avm.avm_readdata[0];
      end
   end
`endif

endmodule
`default_nettype wire
